// File: rtl/axi_master_pkg.sv
// Shared types and AXI encodings for the single-outstanding AXI4 master bridge.
package axi_master_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RADDR = 3'd1,
      S_RDATA = 3'd2,
      S_WADDR = 3'd3,
      S_WDATA = 3'd4,
      S_WRESP = 3'd5
   } state_t;

   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_beat_counter.sv
// Burst beat counter shared by the read and write paths; saturates at len.
module axi_beat_counter (
   input  logic       ACLK,
   input  logic       ARESETn,
   input  logic       i_clr,
   input  logic       i_inc,
   input  logic [3:0] i_len,
   output logic [3:0] o_cnt,
   output logic       o_last
);

   logic [3:0] r_cnt;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn)
         r_cnt <= '0;
      else if (i_clr)
         r_cnt <= '0;
      else if (i_inc && !o_last)
         r_cnt <= r_cnt + 4'd1;
   end

   assign o_cnt  = r_cnt;
   assign o_last = (r_cnt == i_len);

endmodule

// File: rtl/axi_master_bridge.sv
// Single-outstanding AXI4 master: native request port -> one INCR read or write burst.
//   state   | meaning
//   IDLE    | req_ready high, waiting for a native request
//   RADDR   | ARVALID held until ARREADY
//   RDATA   | R beats passed through to the native read stream
//   WADDR   | AWVALID held until AWREADY, W not yet driven
//   WDATA   | native write beats passed through to W, WLAST on final beat
//   WRESP   | BREADY high until the write response arrives
module axi_master_bridge
   import axi_master_pkg::*;
#(
   parameter logic [3:0] MASTER_ID = 4'd0
) (
   input  logic        ACLK,
   input  logic        ARESETn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_len,
   input  logic [2:0]  req_size,
   input  logic [31:0] wr_data,
   input  logic [3:0]  wr_strb,
   input  logic        wr_valid,
   output logic        wr_ready,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        rd_last,
   input  logic        rd_ready,
   output logic        done,
   output logic        done_err,
   output logic [3:0]  ARID,
   output logic [31:0] ARADDR,
   output logic [3:0]  ARLEN,
   output logic [2:0]  ARSIZE,
   output logic [1:0]  ARBURST,
   output logic        ARVALID,
   input  logic        ARREADY,
   input  logic [3:0]  RID,
   input  logic [31:0] RDATA,
   input  logic [1:0]  RRESP,
   input  logic        RLAST,
   input  logic        RVALID,
   output logic        RREADY,
   output logic [3:0]  AWID,
   output logic [31:0] AWADDR,
   output logic [3:0]  AWLEN,
   output logic [2:0]  AWSIZE,
   output logic [1:0]  AWBURST,
   output logic        AWVALID,
   input  logic        AWREADY,
   output logic [31:0] WDATA,
   output logic [3:0]  WSTRB,
   output logic        WLAST,
   output logic        WVALID,
   input  logic        WREADY,
   input  logic [3:0]  BID,
   input  logic [1:0]  BRESP,
   input  logic        BVALID,
   output logic        BREADY
);

   state_t      r_state, w_state_nxt;
   logic        r_live;
   logic [31:0] r_addr;
   logic [3:0]  r_len;
   logic [2:0]  r_size;
   logic        r_err, w_err_nxt;
   logic        r_done, w_done_nxt;
   logic        r_done_err, w_done_err_nxt;
   logic        w_accept, w_cnt_inc, w_last;
   logic [3:0]  w_cnt;
   logic        w_in_rdata, w_in_wdata, w_r_hs, w_w_hs;

   axi_beat_counter u_beat_cnt (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .i_clr   (w_accept),
      .i_inc   (w_cnt_inc),
      .i_len   (r_len),
      .o_cnt   (w_cnt),
      .o_last  (w_last)
   );

   assign w_in_rdata = (r_state == S_RDATA);
   assign w_in_wdata = (r_state == S_WDATA);
   assign w_r_hs     = w_in_rdata && RVALID && rd_ready;
   assign w_w_hs     = w_in_wdata && wr_valid && WREADY;
   assign req_ready  = r_live && (r_state == S_IDLE);

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state    <= S_IDLE;
         r_live     <= 1'b0;
         r_addr     <= '0;
         r_len      <= '0;
         r_size     <= '0;
         r_err      <= 1'b0;
         r_done     <= 1'b0;
         r_done_err <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_live     <= 1'b1;
         r_err      <= w_err_nxt;
         r_done     <= w_done_nxt;
         r_done_err <= w_done_err_nxt;
         if (w_accept) begin
            r_addr <= req_addr;
            r_len  <= req_len;
            r_size <= req_size;
         end
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_err_nxt      = r_err;
      w_done_nxt     = 1'b0;
      w_done_err_nxt = 1'b0;
      w_accept       = 1'b0;
      w_cnt_inc      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               w_accept    = 1'b1;
               w_err_nxt   = 1'b0;
               w_state_nxt = req_write ? S_WADDR : S_RADDR;
            end
         end
         S_RADDR: if (ARREADY) w_state_nxt = S_RDATA;
         S_RDATA: begin
            if (w_r_hs) begin
               w_err_nxt = r_err || (RRESP != RESP_OKAY) || (RID != MASTER_ID);
               if (RLAST) begin
                  // Early RLAST shows up as the counter not yet at len.
                  w_err_nxt      = w_err_nxt || !w_last;
                  w_done_nxt     = 1'b1;
                  w_done_err_nxt = w_err_nxt;
                  w_state_nxt    = S_IDLE;
               end else begin
                  if (w_last) w_err_nxt = 1'b1;
                  w_cnt_inc = 1'b1;
               end
            end
         end
         S_WADDR: if (AWREADY) w_state_nxt = S_WDATA;
         S_WDATA: begin
            if (w_w_hs) begin
               if (w_last) w_state_nxt = S_WRESP;
               else        w_cnt_inc   = 1'b1;
            end
         end
         S_WRESP: begin
            if (BVALID) begin
               w_err_nxt      = r_err || (BRESP != RESP_OKAY) || (BID != MASTER_ID);
               w_done_nxt     = 1'b1;
               w_done_err_nxt = w_err_nxt;
               w_state_nxt    = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign ARID    = MASTER_ID;
   assign ARADDR  = r_addr;
   assign ARLEN   = r_len;
   assign ARSIZE  = r_size;
   assign ARBURST = BURST_INCR;
   assign ARVALID = (r_state == S_RADDR);

   assign rd_data = w_in_rdata ? RDATA : '0;
   assign rd_valid = w_in_rdata && RVALID;
   assign rd_last  = w_in_rdata && RLAST;
   assign RREADY   = w_in_rdata && rd_ready;

   assign AWID    = MASTER_ID;
   assign AWADDR  = r_addr;
   assign AWLEN   = r_len;
   assign AWSIZE  = r_size;
   assign AWBURST = BURST_INCR;
   assign AWVALID = (r_state == S_WADDR);

   assign WDATA    = w_in_wdata ? wr_data : '0;
   assign WSTRB    = w_in_wdata ? wr_strb : '0;
   assign WVALID   = w_in_wdata && wr_valid;
   assign WLAST    = w_in_wdata && w_last;
   assign wr_ready = w_in_wdata && WREADY;
   assign BREADY   = (r_state == S_WRESP);

   assign done     = r_done;
   assign done_err = r_done_err;

endmodule

// File: tb/tb_axi_master_bridge.sv
// Randomized bench: the bench plays requester and AXI slave, predicting beats and error status per burst.
module tb_axi_master_bridge;

   logic        ACLK = 1'b0;
   logic        ARESETn = 1'b0;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr;
   logic [3:0]  req_len;
   logic [2:0]  req_size;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic        wr_valid, wr_ready;
   logic [31:0] rd_data;
   logic        rd_valid, rd_last, rd_ready;
   logic        done, done_err;
   logic [3:0]  ARID, AWID, RID, BID;
   logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
   logic [3:0]  ARLEN, AWLEN, WSTRB;
   logic [2:0]  ARSIZE, AWSIZE;
   logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
   logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
   logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;

   axi_master_bridge dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
      .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
      .done(done), .done_err(done_err),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
   );

   always #5 ACLK = ~ACLK;

   int n_tests = 0;
   int n_fail  = 0;
   int mode    = 0;   // 0 zero-wait, 1 random stalls, 2 alternate cycles
   int cyc     = 0;
   localparam int LIMIT = 200;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic timed_out(input string tag);
      n_tests++;
      n_fail++;
      $display("FAIL %s: no completion within %0d cycles", tag, LIMIT);
   endtask

   function automatic logic pick_hs();
      case (mode)
         0:       return 1'b1;
         2:       return cyc[0];
         default: return ($urandom % 4) != 0;
      endcase
   endfunction

   task automatic step();
      @(posedge ACLK);
      #1;
      cyc++;
   endtask

   task automatic drive_idle();
      req_valid = 0; req_write = 0; req_addr = 0; req_len = 0; req_size = 0;
      wr_data = 0; wr_strb = 0; wr_valid = 0; rd_ready = 0;
      ARREADY = 0; RID = 0; RDATA = 0; RRESP = 0; RLAST = 0; RVALID = 0;
      AWREADY = 0; WREADY = 0; BID = 0; BRESP = 0; BVALID = 0;
   endtask

   task automatic do_reset();
      ARESETn = 0;
      drive_idle();
      repeat (2) @(posedge ACLK);
      #1 ARESETn = 1;
   endtask

   task automatic send_req(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size);
      step();
      req_valid = 1; req_write = wr; req_addr = addr; req_len = len; req_size = size;
      #1;
      check("req_ready_idle", req_ready, 1);
      check("done_before_req", done, 0);
   endtask

   task automatic finish_txn(input logic exp_err);
      #1;
      check("done_pulse", done, 1);
      check("done_err", done_err, exp_err);
      check("req_ready_at_done", req_ready, 1);
      step();
      #1;
      check("done_one_cycle", done, 0);
   endtask

   // last_pos: beat the slave tags with RLAST; bad_at/badid_at: beat carrying a bad RRESP/RID (-1 none)
   task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                          input int last_pos, input int bad_at, input int badid_at,
                          input logic [31:0] d0);
      logic [31:0] dq[$];
      int   beat, budget;
      logic exp_err;
      for (int i = 0; i <= last_pos; i++) dq.push_back(i == 0 ? d0 : $urandom);
      exp_err = (last_pos != int'(len)) || (bad_at >= 0 && bad_at <= last_pos) ||
                (badid_at >= 0 && badid_at <= last_pos);
      send_req(1'b0, addr, len, size);
      step();
      req_valid = 0; rd_ready = 1; ARREADY = pick_hs();
      #1;
      check("arvalid_after_accept", ARVALID, 1);
      check("araddr", ARADDR, addr);
      check("arlen", ARLEN, len);
      check("arsize", ARSIZE, size);
      check("arburst", ARBURST, 2'b01);
      check("arid", ARID, 0);
      check("rready_during_ar", RREADY, 0);
      budget = 0;
      while (!ARREADY) begin
         if (++budget > LIMIT) begin timed_out("ar_wait"); do_reset(); return; end
         step();
         ARREADY = pick_hs();
         #1;
         check("arvalid_hold", ARVALID, 1);
      end
      step();
      ARREADY = 0;
      beat = 0; budget = 0;
      forever begin
         RVALID   = pick_hs();
         rd_ready = pick_hs();
         RDATA    = RVALID ? dq[beat] : $urandom;
         RLAST    = RVALID && (beat == last_pos);
         RRESP    = (RVALID && beat == bad_at) ? 2'(1 + $urandom % 3) : 2'b00;
         RID      = (RVALID && beat == badid_at) ? 4'(1 + $urandom % 15) : 4'd0;
         #1;
         check("rd_valid", rd_valid, RVALID);
         check("rready_mirror", RREADY, rd_ready);
         check("arvalid_after_ar", ARVALID, 0);
         check("done_mid_read", done, 0);
         if (RVALID) begin
            check("rd_data", rd_data, dq[beat]);
            check("rd_last", rd_last, beat == last_pos);
         end
         if (RVALID && rd_ready) begin
            if (beat == last_pos) break;
            beat++;
         end
         if (++budget > LIMIT) begin timed_out("r_wait"); do_reset(); return; end
         step();
      end
      step();
      RVALID = 0; RLAST = 0; RRESP = 0; RID = 0; rd_ready = 0;
      finish_txn(exp_err);
   endtask

   // strb < 0 picks random strobes per beat
   task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                           input logic [1:0] bresp, input logic [3:0] bid, input int strb);
      logic [31:0] wq[$];
      logic [3:0]  sq[$];
      int   beat, budget;
      for (int i = 0; i <= int'(len); i++) begin
         wq.push_back($urandom);
         sq.push_back(strb < 0 ? 4'($urandom) : 4'(strb));
      end
      send_req(1'b1, addr, len, size);
      step();
      req_valid = 0; wr_valid = 1; wr_data = 32'hA5A5_A5A5; WREADY = 1; AWREADY = pick_hs();
      #1;
      check("awvalid_after_accept", AWVALID, 1);
      check("awaddr", AWADDR, addr);
      check("awlen", AWLEN, len);
      check("awsize", AWSIZE, size);
      check("awburst", AWBURST, 2'b01);
      check("awid", AWID, 0);
      check("wvalid_before_aw", WVALID, 0);
      check("wr_ready_before_aw", wr_ready, 0);
      budget = 0;
      while (!AWREADY) begin
         if (++budget > LIMIT) begin timed_out("aw_wait"); do_reset(); return; end
         step();
         AWREADY = pick_hs();
         #1;
         check("awvalid_hold", AWVALID, 1);
         check("wvalid_before_aw", WVALID, 0);
      end
      step();
      AWREADY = 0;
      beat = 0; budget = 0;
      forever begin
         wr_valid = pick_hs();
         WREADY   = pick_hs();
         wr_data  = wq[beat];
         wr_strb  = sq[beat];
         #1;
         check("wvalid", WVALID, wr_valid);
         check("wr_ready", wr_ready, WREADY);
         check("bready_during_w", BREADY, 0);
         if (wr_valid) begin
            check("wdata_order", WDATA, wq[beat]);
            check("wstrb", WSTRB, sq[beat]);
            check("wlast", WLAST, beat == int'(len));
         end
         if (wr_valid && WREADY) begin
            if (beat == int'(len)) break;
            beat++;
         end
         if (++budget > LIMIT) begin timed_out("w_wait"); do_reset(); return; end
         step();
      end
      step();
      wr_valid = 0; WREADY = 0; budget = 0;
      forever begin
         BVALID = pick_hs();
         BRESP  = bresp;
         BID    = bid;
         #1;
         check("bready", BREADY, 1);
         check("wvalid_after_w", WVALID, 0);
         check("done_mid_write", done, 0);
         if (BVALID) break;
         if (++budget > LIMIT) begin timed_out("b_wait"); do_reset(); return; end
         step();
      end
      step();
      BVALID = 0; BRESP = 0; BID = 0;
      finish_txn((bresp != 2'b00) || (bid != 4'd0));
   endtask

   task automatic reset_mid_read();
      send_req(1'b0, 32'h0000_6000, 4'd3, 3'd2);
      step();
      req_valid = 0; ARREADY = 1;
      step();
      ARREADY = 0; RVALID = 1; rd_ready = 1; RDATA = 32'h1111_1111; RLAST = 0;
      step();
      RDATA = 32'h2222_2222;
      #1;
      check("rd_valid_beat2", rd_valid, 1);
      ARESETn = 0;
      #1;
      check("rst_req_ready", req_ready, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_rready", RREADY, 0);
      check("rst_arvalid", ARVALID, 0);
      check("rst_araddr", ARADDR, 0);
      check("rst_awvalid", AWVALID, 0);
      check("rst_wvalid", WVALID, 0);
      check("rst_bready", BREADY, 0);
      check("rst_done", done, 0);
      drive_idle();
      repeat (2) begin
         @(posedge ACLK);
         #1;
         check("rst_no_done", done, 0);
      end
      ARESETn = 1;
      step();
      #1;
      check("req_ready_after_release", req_ready, 1);
      check("no_done_after_abort", done, 0);
   endtask

   initial begin
      int   len, lp, ba, bi;
      logic [2:0] sz;
      logic [31:0] ad;
      drive_idle();
      #2;
      check("reset_req_ready", req_ready, 0);
      check("reset_arvalid", ARVALID, 0);
      check("reset_awvalid", AWVALID, 0);
      check("reset_wlast", WLAST, 0);
      check("reset_done", done, 0);
      check("reset_done_err", done_err, 0);
      check("reset_awaddr", AWADDR, 0);
      @(posedge ACLK);
      #1 ARESETn = 1;
      step();
      check("req_ready_first_cycle", req_ready, 1);

      mode = 0; do_read(32'h0000_1000, 4'd0, 3'd2, 0, -1, -1, 32'hDEAD_BEEF);
      mode = 2; do_read(32'h0000_2000, 4'd3, 3'd2, 3, -1, -1, $urandom);
      mode = 2; do_write(32'h0000_3000, 4'd3, 3'd2, 2'b00, 4'd0, 4'b0011);
      mode = 1; do_write(32'h0000_4000, 4'd1, 3'd2, 2'b10, 4'd0, -1);
      mode = 1; do_read(32'h0000_5000, 4'd3, 3'd2, 1, -1, -1, $urandom);
      mode = 0; do_read(32'h0000_5100, 4'd2, 3'd1, 4, -1, -1, $urandom);
      mode = 0; reset_mid_read();
      mode = 0; do_write(32'h0000_7000, 4'd0, 3'd0, 2'b00, 4'd0, 4'b0001);

      for (int t = 0; t < 40; t++) begin
         mode = ($urandom % 3 == 0) ? 0 : 1;
         len  = $urandom % 16;
         sz   = 3'($urandom % 3);
         ad   = $urandom & ~((32'd1 << sz) - 32'd1);
         if ($urandom % 2) begin
            do_write(ad, 4'(len), sz, ($urandom % 4 == 0) ? 2'($urandom) : 2'b00,
                     ($urandom % 8 == 0) ? 4'(1 + $urandom % 15) : 4'd0, -1);
         end else begin
            lp = ($urandom % 4 == 0) ? int'($urandom % (len + 3)) : len;
            ba = ($urandom % 5 == 0) ? int'($urandom % (lp + 1)) : -1;
            bi = ($urandom % 8 == 0) ? int'($urandom % (lp + 1)) : -1;
            do_read(ad, 4'(len), sz, lp, ba, bi, $urandom);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
